// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the RV64M iterative multiply/divide unit.
// Imported by ex_muldiv and its result-formatting sub-module.
package ex_muldiv_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [2*XLEN-1:0] ZERO_128 = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic [XLEN-1:0] sext32(
    input logic [31:0] v
  );
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/ex_muldiv_signfix.sv
// Result formatting for ex_muldiv: sign correction, half/quotient/remainder
// select and word-op sign extension.
module ex_muldiv_signfix
  import ex_muldiv_pkg::*;
(
  input  logic              is_mul_i,
  input  logic              sel_hi_i,
  input  logic              sel_rem_i,
  input  logic              neg_res_i,
  input  logic              neg_rem_i,
  input  logic              word_i,
  input  logic              byp_i,
  input  logic [XLEN-1:0]   byp_val_i,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [XLEN-1:0]   res_o
);

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   raw;

  always_comb begin
    // Word multiplies run half the iterations, so the product sits 32 bits up.
    prod     = word_i ? {32'b0, acc_i[2*XLEN-1:32]} : acc_i;
    prod_fix = neg_res_i ? -prod : prod;
    quot     = neg_res_i ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
    rem      = neg_rem_i ? -acc_i[2*XLEN-1:XLEN]
                         : acc_i[2*XLEN-1:XLEN];
    if (byp_i) begin
      raw = byp_val_i;
    end else if (is_mul_i) begin
      raw = sel_hi_i ? prod_fix[2*XLEN-1:XLEN]
                     : prod_fix[XLEN-1:0];
    end else begin
      raw = sel_rem_i ? rem : quot;
    end
    res_o = word_i ? sext32(raw[31:0]) : raw;
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide unit in EX: shift-add multiply and
// restoring divide, one bit per cycle, stalling the pipe while busy.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            md_valid_i,
  input  logic [2:0]      md_funct3_i,
  input  logic            md_word_i,
  input  logic [XLEN-1:0] md_rs1_i,
  input  logic [XLEN-1:0] md_rs2_i,
  input  logic            md_flush_i,
  output logic            md_stall_req,
  output logic [XLEN-1:0] md_result_o,
  output logic            md_result_valid,
  output logic            md_busy_o
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              mul_q, mul_d;
  logic              hi_q, hi_d;
  logic              rem_q, rem_d;
  logic              negr_q, negr_d;
  logic              negm_q, negm_d;
  logic              word_q, word_d;
  logic              byp_q, byp_d;
  logic [XLEN-1:0]   bypv_q, bypv_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              vld_q, vld_d;
  logic [XLEN-1:0]   fix_res;

  logic              dec_mul;
  logic              a_sgn, b_sgn;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_ext, b_ext;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div0, ovf;

  always_comb begin
    dec_mul = !md_funct3_i[2];
    a_sgn   = 1'b0;
    b_sgn   = 1'b0;
    unique case (md_funct3_i)
      MD_MUL, MD_MULHU, MD_DIVU, MD_REMU: begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
      end
      MD_MULH, MD_DIV, MD_REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      MD_MULHSU: a_sgn = 1'b1;
      default: ;
    endcase
    a_ext = md_word_i
          ? (a_sgn ? sext32(md_rs1_i[31:0]) : {32'b0, md_rs1_i[31:0]})
          : md_rs1_i;
    b_ext = md_word_i
          ? (b_sgn ? sext32(md_rs2_i[31:0]) : {32'b0, md_rs2_i[31:0]})
          : md_rs2_i;
    a_neg = a_sgn && a_ext[XLEN-1];
    b_neg = b_sgn && b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    div0  = md_word_i ? (b_ext[31:0] == 32'b0) : (b_ext == '0);
    ovf   = a_sgn && b_sgn && !dec_mul && (md_word_i
          ? (a_ext[31:0] == 32'h8000_0000 && b_ext[31:0] == 32'hFFFF_FFFF)
          : (a_ext == {1'b1, {(XLEN-1){1'b0}}} && b_ext == '1));
  end

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_sub;
  logic              div_ge;
  logic [2*XLEN-1:0] div_nxt;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
            + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
    mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
    // Shifted partial remainder needs one extra bit before the compare.
    rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge  = rem_sh >= {1'b0, opb_q};
    rem_sub = rem_sh[XLEN-1:0] - opb_q;
    div_nxt = {div_ge ? rem_sub : rem_sh[XLEN-1:0],
               acc_q[XLEN-2:0], div_ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    mul_d   = mul_q;
    hi_d    = hi_q;
    rem_d   = rem_q;
    negr_d  = negr_q;
    negm_d  = negm_q;
    word_d  = word_q;
    byp_d   = byp_q;
    bypv_d  = bypv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (md_valid_i && !md_flush_i) begin
          mul_d  = dec_mul;
          hi_d   = dec_mul && (md_funct3_i[1:0] != 2'b00);
          rem_d  = md_funct3_i[1];
          word_d = md_word_i;
          negr_d = a_neg ^ b_neg;
          negm_d = a_neg;
          byp_d  = !dec_mul && (div0 || ovf);
          if (div0) begin
            bypv_d = md_funct3_i[1] ? a_ext : '1;
          end else begin
            bypv_d = md_funct3_i[1] ? '0 : a_ext;
          end
          cnt_d = md_word_i ? CNT_W'(XLEN/2) : CNT_W'(XLEN);
          if (dec_mul) begin
            opb_d = md_word_i ? {32'b0, a_mag[31:0]} : a_mag;
            acc_d = {{XLEN{1'b0}},
                     md_word_i ? {32'b0, b_mag[31:0]} : b_mag};
          end else begin
            opb_d = md_word_i ? {32'b0, b_mag[31:0]} : b_mag;
            acc_d = {{XLEN{1'b0}},
                     md_word_i ? {a_mag[31:0], 32'b0} : a_mag};
          end
          state_d = byp_d ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q - 1'b1;
        acc_d = mul_q ? mul_nxt : div_nxt;
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (md_flush_i) state_d = ST_IDLE;
  end

  ex_muldiv_signfix u_signfix (
    .is_mul_i  (mul_d),
    .sel_hi_i  (hi_d),
    .sel_rem_i (rem_d),
    .neg_res_i (negr_d),
    .neg_rem_i (negm_d),
    .word_i    (word_d),
    .byp_i     (byp_d),
    .byp_val_i (bypv_d),
    .acc_i     (acc_d),
    .res_o     (fix_res)
  );

  always_comb begin
    vld_d = (state_d == ST_DONE);
    res_d = vld_d ? fix_res : res_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= ZERO_128;
      opb_q   <= '0;
      mul_q   <= 1'b0;
      hi_q    <= 1'b0;
      rem_q   <= 1'b0;
      negr_q  <= 1'b0;
      negm_q  <= 1'b0;
      word_q  <= 1'b0;
      byp_q   <= 1'b0;
      bypv_q  <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      mul_q   <= mul_d;
      hi_q    <= hi_d;
      rem_q   <= rem_d;
      negr_q  <= negr_d;
      negm_q  <= negm_d;
      word_q  <= word_d;
      byp_q   <= byp_d;
      bypv_q  <= bypv_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

  assign md_stall_req = (state_q == ST_IDLE && md_valid_i && !md_flush_i)
                     || (state_q == ST_CALC);
  assign md_result_o     = res_q;
  assign md_result_valid = vld_q;
  assign md_busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: random and directed M-ext ops checked
// against a plain-arithmetic reference model.
module tb_ex_muldiv;

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_valid_i;
  logic [2:0]  md_funct3_i;
  logic        md_word_i;
  logic [63:0] md_rs1_i;
  logic [63:0] md_rs2_i;
  logic        md_flush_i;
  logic        md_stall_req;
  logic [63:0] md_result_o;
  logic        md_result_valid;
  logic        md_busy_o;

  ex_muldiv dut (
    .clk             (clk),
    .rst             (rst),
    .md_valid_i      (md_valid_i),
    .md_funct3_i     (md_funct3_i),
    .md_word_i       (md_word_i),
    .md_rs1_i        (md_rs1_i),
    .md_rs2_i        (md_rs2_i),
    .md_flush_i      (md_flush_i),
    .md_stall_req    (md_stall_req),
    .md_result_o     (md_result_o),
    .md_result_valid (md_result_valid),
    .md_busy_o       (md_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [2:0]  f;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] ref_md(input logic [2:0] f,
      input logic w, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb;
    logic [127:0]        p;
    logic signed [63:0]  sa, sb;
    logic signed [31:0]  sa32, sb32;
    logic [31:0]         a32, b32, r32;
    logic [63:0]         r;
    sa = a; sb = b;
    a32 = a[31:0]; b32 = b[31:0];
    sa32 = a32; sb32 = b32;
    r = '0; r32 = '0;
    if (w) begin
      case (f)
        F_MUL: r32 = a32 * b32;
        F_DIV:
          if (b32 == 0) r32 = '1;
          else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
          else r32 = sa32 / sb32;
        F_DIVU:
          if (b32 == 0) r32 = '1;
          else r32 = a32 / b32;
        F_REM:
          if (b32 == 0) r32 = a32;
          else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
          else r32 = sa32 % sb32;
        F_REMU:
          if (b32 == 0) r32 = a32;
          else r32 = a32 % b32;
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (f)
        F_MUL: r = a * b;
        F_MULH: begin
          pa = sa; pb = sb; p = pa * pb; r = p[127:64];
        end
        F_MULHSU: begin
          pa = sa; pb = {64'b0, b}; p = pa * pb; r = p[127:64];
        end
        F_MULHU: begin
          p = {64'b0, a} * {64'b0, b}; r = p[127:64];
        end
        F_DIV:
          if (b == 0) r = '1;
          else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
          else r = sa / sb;
        F_DIVU:
          if (b == 0) r = '1;
          else r = a / b;
        F_REM:
          if (b == 0) r = a;
          else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
          else r = sa % sb;
        default:
          if (b == 0) r = a;
          else r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic w,
      input logic [63:0] a, input logic [63:0] b);
    logic zero, ov;
    if (f < 3'd4) return w ? 33 : 65;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ov = (f == F_DIV || f == F_REM) && (w
       ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
       : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (zero || ov) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] r;
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = 64'd1;
      2: r = '1;
      3: r = 64'h8000_0000_0000_0000;
      4: r = {$urandom, 32'h8000_0000};
      5: r = 64'($urandom_range(0, 40)) - 64'd20;
      6: r = {32'h0, $urandom};
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (md_result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_result_valid", md_result_o, 64'hx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("result f=%0d w=%0d a=%h b=%h",
              e.f, e.w, e.a, e.b), md_result_o, e.res);
      end
    end
  end

  task automatic drive_op(input logic [2:0] f, input logic w,
      input logic [63:0] a, input logic [63:0] b, input bit push);
    exp_t e;
    md_valid_i  = 1'b1;
    md_funct3_i = f;
    md_word_i   = w;
    md_rs1_i    = a;
    md_rs2_i    = b;
    if (push) begin
      e.res = ref_md(f, w, a, b);
      e.f = f; e.w = w; e.a = a; e.b = b;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic w,
      input logic [63:0] a, input logic [63:0] b);
    int lat;
    bit bad;
    drive_op(f, w, a, b, 1'b1);
    #1;
    bad = (md_stall_req !== 1'b1);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (md_result_valid === 1'b1) break;
      if (md_stall_req !== 1'b1 || md_busy_o !== 1'b1) bad = 1'b1;
    end
    check($sformatf("latency f=%0d w=%0d", f, w),
          64'(lat), 64'(ref_lat(f, w, a, b)));
    check("stall_during_op", {63'b0, bad}, 64'd0);
    check("stall_in_done", {63'b0, md_stall_req}, 64'd0);
    md_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    md_valid_i = 1'b0;
    md_funct3_i = '0;
    md_word_i = 1'b0;
    md_rs1_i = '0;
    md_rs2_i = '0;
    md_flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_result", md_result_o, 64'd0);
    check("reset_valid", {63'b0, md_result_valid}, 64'd0);
    check("reset_busy", {63'b0, md_busy_o}, 64'd0);
    check("reset_stall", {63'b0, md_stall_req}, 64'd0);
    rst = 1'b1;

    @(negedge clk); run_op(F_MUL, 1'b0, 64'd7, -64'd3);
    @(negedge clk); run_op(F_MULHU, 1'b0, '1, '1);
    @(negedge clk); run_op(F_MULH, 1'b0, '1, '1);
    @(negedge clk); run_op(F_MULHSU, 1'b0, '1, '1);
    @(negedge clk); run_op(F_DIV, 1'b0, -64'd7, 64'd2);
    @(negedge clk); run_op(F_REM, 1'b0, -64'd7, 64'd2);
    @(negedge clk); run_op(F_DIVU, 1'b0, 64'd7, 64'd0);
    @(negedge clk); run_op(F_REMU, 1'b0, 64'd7, 64'd0);
    @(negedge clk); run_op(F_DIV, 1'b0, 64'h8000_0000_0000_0000, '1);
    @(negedge clk); run_op(F_REM, 1'b0, 64'h8000_0000_0000_0000, '1);
    @(negedge clk); run_op(F_DIV, 1'b1, 64'h8000_0000, '1);
    @(negedge clk); run_op(F_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2);
    @(negedge clk);
    run_op(F_DIVU, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_0000_0007);
    @(negedge clk); run_op(F_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2);

    // Flush mid-calculation, then immediately issue a new multiply.
    @(negedge clk);
    drive_op(F_MUL, 1'b0, 64'd12345, 64'd678, 1'b0);
    repeat (10) @(negedge clk);
    md_flush_i = 1'b1;
    @(negedge clk);
    md_flush_i = 1'b0;
    check("flush_busy", {63'b0, md_busy_o}, 64'd0);
    check("flush_valid", {63'b0, md_result_valid}, 64'd0);
    run_op(F_MUL, 1'b0, 64'd1000003, 64'd99991);

    // Reset in the middle of a divide.
    @(negedge clk);
    drive_op(F_DIV, 1'b0, 64'd1000, 64'd7, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    md_valid_i = 1'b0;
    @(negedge clk);
    check("midrst_result", md_result_o, 64'd0);
    check("midrst_valid", {63'b0, md_result_valid}, 64'd0);
    check("midrst_busy", {63'b0, md_busy_o}, 64'd0);
    check("midrst_stall", {63'b0, md_stall_req}, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 150; i++) begin
      logic [2:0] f;
      logic w;
      f = 3'($urandom_range(0, 7));
      w = (f == F_MUL || f[2]) && ($urandom_range(0, 2) == 0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      run_op(f, w, pick(), pick());
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
